// File: rtl/min_z.sv
// min_z: registered 4-input Boolean function unit.
// The function is a 16-entry truth table carried in MINTERMS; bit i of the
// table is the result for input index i = {a,b,c,d}, with a as the MSB.
// The default table is sum(1,2,3,6,10,12,13,14,15), whose minimised cover is
// (a&b) | (c&~d) | (~a&~b&d).
//
// Interface timing: there is no valid/ready handshake and no enable. A new
// input vector is sampled on every rising edge of clk. Its result appears on z
// after that edge, so the latency is exactly one cycle. Input changes between
// edges do not reach z, because there is no combinational path from a..d to z.
module min_z #(
  parameter logic [15:0] MINTERMS = 16'hF44E
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic z
);

  logic [3:0] idx;
  logic       f;

  // Build the truth-table index and look up the function value.
  always_comb begin
    idx = {a, b, c, d};
    f   = MINTERMS[idx];
  end

  // Register the result. A synchronous reset takes priority over the inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= 1'b0;
    end else begin
      z <= f;
    end
  end

endmodule

// File: tb/tb_min_z.sv
// tb_min_z: directed bench for min_z.
// It drives two instances from the same stimulus: the default truth table and
// an override of 16'h8000, which is a 4-input AND.
// Expected values come from independent Boolean models and are queued when a
// vector is driven. They are popped and compared one edge later.
module tb_min_z;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic z_def;
  logic z_and;

  logic [0:0] exp_q[$];
  logic [0:0] exp_and_q[$];
  logic [0:0] last_def;
  logic [0:0] last_and;

  int n_cmp;
  int n_err;

  min_z dut_def (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .z   (z_def)
  );

  min_z #(.MINTERMS(16'h8000)) dut_and (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .z   (z_and)
  );

  // Clock and reset: 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of the default function, written as the minimised sum of products.
  function automatic logic model_def(input logic [3:0] v);
    logic va, vb, vc, vd;
    {va, vb, vc, vd} = v;
    return (va & vb) | (vc & ~vd) | (~va & ~vb & vd);
  endfunction

  // Model of the override function: true only when all four inputs are high.
  function automatic logic model_and(input logic [3:0] v);
    return v[3] & v[2] & v[1] & v[0];
  endfunction

  // Compare one observed value with its expectation and count the result.
  task automatic check(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Driver: apply a vector and reset level at the falling edge, and queue the
  // expected results. Then wait for the rising edge and score both instances.
  task automatic step(input logic [3:0] v, input logic r, input string tag);
    logic [0:0] e_def;
    logic [0:0] e_and;
    @(negedge clk);
    {a, b, c, d} = v;
    rst = r;
    exp_q.push_back(r ? 1'b0 : model_def(v));
    exp_and_q.push_back(r ? 1'b0 : model_and(v));
    @(posedge clk);
    #1;
    e_def = exp_q.pop_front();
    e_and = exp_and_q.pop_front();
    last_def = e_def;
    last_and = e_and;
    check({tag, "/def"}, z_def, e_def[0]);
    check({tag, "/and"}, z_and, e_and[0]);
  endtask

  // Directed sequence.
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    {a, b, c, d} = 4'b1111;
    last_def = 1'b0;
    last_and = 1'b0;

    // Reset held for two cycles with all inputs high, then released.
    step(4'b1111, 1'b1, "reset0");
    step(4'b1111, 1'b1, "reset1");
    step(4'b1111, 1'b0, "reset_release");

    // Exhaustive sweep, one vector per cycle.
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0, $sformatf("sweep%0d", i));
    end

    // Latency: an input change between edges must not reach z early.
    step(4'b0000, 1'b0, "lat_base");
    {a, b, c, d} = 4'b0001;
    #2;
    check("lat_hold/def", z_def, last_def[0]);
    check("lat_hold/and", z_and, last_and[0]);
    step(4'b0001, 1'b0, "lat_edge");

    // Reset asserted mid-stream with the inputs held at 1100.
    step(4'b1100, 1'b0, "mid_pre");
    step(4'b1100, 1'b1, "mid_rst");
    step(4'b1100, 1'b0, "mid_post");

    // Back-to-back changes: alternate 0110 and 0111 every cycle.
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 4'b0110 : 4'b0111, 1'b0, $sformatf("alt%0d", i));
    end

    // Random vectors, with an occasional reset.
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0), $sformatf("rand%0d", i));
    end

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
